// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register block host interface.
//   rggen_status         : response status reported by the register array
//   rggen_bridge_state_e : APB bridge FSM states (IDLE -> BUSY -> RESPOND)
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY        = 2'b00,
    RGGEN_EXOKAY      = 2'b01,
    RGGEN_SLAVE_ERROR = 2'b10
  } rggen_status;

  typedef enum logic [1:0] {
    BRIDGE_IDLE    = 2'd0,
    BRIDGE_BUSY    = 2'd1,
    BRIDGE_RESPOND = 2'd2
  } rggen_bridge_state_e;

endpackage

// File: rtl/rggen_bus_timeout_counter.sv
// Cycle counter that bounds how long the bridge waits for a register response.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : forces the count to zero (held while the bridge is idle)
//   i_enable    : advances the count by one per cycle
//   o_expired   : high while the count equals TIMEOUT_CYCLES-1
module rggen_bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rggen_apb_bridge.sv
// APB slave front end of the register block. Converts each APB transfer into
// one internal request/response access (single outstanding, registered outputs).
// Optional feature: define RGGEN_APB_BRIDGE_TIMEOUT_EN to bound the BUSY wait
// to TIMEOUT_CYCLES cycles, after which the transfer ends with PSLVERR.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   i_psel .. i_pwdata                 : APB request
//   o_pready, o_prdata, o_pslverr      : APB response
//   o_request_valid .. o_strobe        : internal access request
//   i_response_ready/_status, i_read_data : pre-OR-reduced register array response
// Handshake: o_request_valid rises the cycle after the APB setup phase and the
// request fields stay stable until a cycle with i_response_ready=1 (or a
// timeout); the response is returned as a one-cycle o_pready pulse.
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic                      i_pwrite,
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  output logic                      o_pready,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pslverr,
  output logic                      o_request_valid,
  output logic [ADDRESS_WIDTH-1:0]  o_address,
  output logic                      o_write,
  output logic [DATA_WIDTH-1:0]     o_write_data,
  output logic [DATA_WIDTH-1:0]     o_strobe,
  input  logic                      i_response_ready,
  input  logic [1:0]                i_response_status,
  input  logic [DATA_WIDTH-1:0]     i_read_data
);

  localparam int STROBE_BYTES = DATA_WIDTH / 8;

  rggen_bridge_state_e       state_q, state_d;
  logic                      req_valid_q, req_valid_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic                      write_q, write_d;
  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]     strobe_q, strobe_d;
  logic                      pready_q, pready_d;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
  logic                      pslverr_q, pslverr_d;
  logic                      abort_q, abort_d;
  logic [DATA_WIDTH-1:0]     strobe_expand;
  logic                      aborted;
  logic                      timeout_expired;

  // Byte strobes widened to one bit per data bit.
  for (genvar g = 0; g < STROBE_BYTES; g++) begin : g_strobe
    assign strobe_expand[8*g +: 8] = {8{i_pstrb[g]}};
  end

  // The master dropped PSEL at some point while the access was in flight:
  // the access still finishes, but its APB response is suppressed.
  assign aborted = abort_q | ~i_psel;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  // Held clear while idle so the first BUSY cycle counts as zero.
  rggen_bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (state_q == BRIDGE_IDLE),
    .i_enable  (state_q == BRIDGE_BUSY),
    .o_expired (timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_expired    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    address_d    = address_q;
    write_d      = write_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    pready_d     = pready_q;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    abort_d      = abort_q;
    case (state_q)
      BRIDGE_IDLE: begin
        if (i_psel && !i_penable) begin
          state_d     = BRIDGE_BUSY;
          req_valid_d = 1'b1;
          address_d   = i_paddr;
          write_d     = i_pwrite;
          abort_d     = 1'b0;
          if (i_pwrite) begin
            write_data_d = i_pwdata;
            strobe_d     = strobe_expand;
          end else begin
            strobe_d     = '1;
          end
        end
      end
      BRIDGE_BUSY: begin
        if (!i_psel) begin
          abort_d = 1'b1;
        end
        // A real response wins over a timeout expiring in the same cycle.
        if (i_response_ready) begin
          state_d     = BRIDGE_RESPOND;
          req_valid_d = 1'b0;
          pready_d    = ~aborted;
          prdata_d    = (!write_q && !aborted) ? i_read_data : '0;
          pslverr_d   = ~aborted && (i_response_status == RGGEN_SLAVE_ERROR);
        end else if (timeout_expired) begin
          state_d     = BRIDGE_RESPOND;
          req_valid_d = 1'b0;
          pready_d    = ~aborted;
          prdata_d    = '0;
          pslverr_d   = ~aborted;
        end
      end
      BRIDGE_RESPOND: begin
        state_d   = BRIDGE_IDLE;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
      default: begin
        state_d = BRIDGE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BRIDGE_IDLE;
      req_valid_q  <= 1'b0;
      address_q    <= '0;
      write_q      <= 1'b0;
      write_data_q <= '0;
      strobe_q     <= '0;
      pready_q     <= 1'b0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      address_q    <= address_d;
      write_q      <= write_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      pready_q     <= pready_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      abort_q      <= abort_d;
    end
  end

  assign o_request_valid = req_valid_q;
  assign o_address       = address_q;
  assign o_write         = write_q;
  assign o_write_data    = write_data_q;
  assign o_strobe        = strobe_q;
  assign o_pready        = pready_q;
  assign o_prdata        = prdata_q;
  assign o_pslverr       = pslverr_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Self-checking bench for rggen_apb_bridge: directed scenarios followed by
// randomized APB transfers, all compared against a transaction-level model.
module tb_rggen_apb_bridge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAX_DELAY = TO_EN ? 12 : 5;

  logic          clk;
  logic          rst_n;
  logic          i_psel;
  logic          i_penable;
  logic [AW-1:0] i_paddr;
  logic          i_pwrite;
  logic [SW-1:0] i_pstrb;
  logic [DW-1:0] i_pwdata;
  logic          o_pready;
  logic [DW-1:0] o_prdata;
  logic          o_pslverr;
  logic          o_request_valid;
  logic [AW-1:0] o_address;
  logic          o_write;
  logic [DW-1:0] o_write_data;
  logic [DW-1:0] o_strobe;
  logic          i_response_ready;
  logic [1:0]    i_response_status;
  logic [DW-1:0] i_read_data;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {pslverr, prdata} expected for each issued transfer.
  logic [DW:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_psel            (i_psel),
    .i_penable         (i_penable),
    .i_paddr           (i_paddr),
    .i_pwrite          (i_pwrite),
    .i_pstrb           (i_pstrb),
    .i_pwdata          (i_pwdata),
    .o_pready          (o_pready),
    .o_prdata          (o_prdata),
    .o_pslverr         (o_pslverr),
    .o_request_valid   (o_request_valid),
    .o_address         (o_address),
    .o_write           (o_write),
    .o_write_data      (o_write_data),
    .o_strobe          (o_strobe),
    .i_response_ready  (i_response_ready),
    .i_response_status (i_response_status),
    .i_read_data       (i_read_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: bit strobe seen by the register array.
  function automatic logic [DW-1:0] model_strobe(input logic wr, input logic [SW-1:0] strb);
    logic [DW-1:0] s;
    for (int b = 0; b < DW; b++) s[b] = wr ? strb[b/8] : 1'b1;
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_pready"}, o_pready, 0);
    check({tag, "_prdata"}, o_prdata, 0);
    check({tag, "_pslverr"}, o_pslverr, 0);
    check({tag, "_req_valid"}, o_request_valid, 0);
    check({tag, "_address"}, o_address, 0);
    check({tag, "_write"}, o_write, 0);
    check({tag, "_write_data"}, o_write_data, 0);
    check({tag, "_strobe"}, o_strobe, 0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge while the bridge is idle; returns at the negedge of
  // the idle cycle following the response, so calls chain back-to-back.
  // delay = number of BUSY cycles before i_response_ready is raised.
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          input int delay, input logic [1:0] status,
                          input logic [DW-1:0] rdata);
    bit          timed_out;
    int          resp_idx;
    logic [DW:0] exp_resp;
    timed_out = TO_EN && (delay > TO - 1);
    resp_idx  = timed_out ? TO - 1 : delay;
    exp_q.push_back({(timed_out || status == 2'b10), ((wr || timed_out) ? {DW{1'b0}} : rdata)});
    // setup phase
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = addr; i_pwrite = wr;
    i_pwdata = wdata; i_pstrb = strb; i_response_ready = 1'b0;
    @(negedge clk);
    check("req_address", o_address, addr);
    check("req_write", o_write, wr);
    check("req_strobe", o_strobe, model_strobe(wr, strb));
    if (wr) check("req_write_data", o_write_data, wdata);
    i_penable = 1'b1;
    // access cycles k = 1, 2, ...; pready expected in cycle resp_idx+2
    for (int k = 1; k <= resp_idx + 2; k++) begin
      if (k <= resp_idx + 1) begin
        check("wait_pready", o_pready, 0);
        check("busy_req_valid", o_request_valid, 1);
        check("busy_address", o_address, addr);
        i_response_ready = (k - 1 == delay);
        // junk status/data when not responding must be ignored
        i_response_status = (k - 1 == delay) ? status : 2'b10;
        i_read_data       = (k - 1 == delay) ? rdata : $urandom;
        @(negedge clk);
      end else begin
        i_response_ready = 1'b0;
        exp_resp = exp_q.pop_front();
        check("resp_pready", o_pready, 1);
        check("resp_pslverr", o_pslverr, exp_resp[DW]);
        check("resp_prdata", o_prdata, exp_resp[DW-1:0]);
        check("resp_req_valid", o_request_valid, 0);
      end
    end
    i_psel = 1'b0; i_penable = 1'b0;
    @(negedge clk);
    check("idle_pready", o_pready, 0);
    check("idle_prdata", o_prdata, 0);
    check("idle_pslverr", o_pslverr, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    i_psel = 1'b0; i_penable = 1'b0; i_paddr = '0; i_pwrite = 1'b0;
    i_pstrb = '0; i_pwdata = '0; i_response_ready = 1'b0;
    i_response_status = 2'b00; i_read_data = '0;
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // write with response after 3 BUSY cycles
    apb_xfer(16'h0010, 1'b1, 32'hDEADBEEF, 4'b0011, 3, 2'b00, 32'hFFFF_FFFF);
    // read with immediate response
    apb_xfer(16'h0020, 1'b0, 32'h0, 4'h0, 0, 2'b00, 32'h12345678);
    // read answered with SLAVE_ERROR
    apb_xfer(16'h0030, 1'b0, 32'h0, 4'h0, 1, 2'b10, 32'hA5A5A5A5);
    // EXOKAY is not an error
    apb_xfer(16'h0034, 1'b0, 32'h0, 4'h0, 2, 2'b01, 32'h0BADF00D);

    // reset in the middle of BUSY
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = 16'h0044; i_pwrite = 1'b1;
    i_pwdata = 32'hCAFEF00D; i_pstrb = 4'hF;
    @(negedge clk);
    check("rst_pre_req_valid", o_request_valid, 1);
    i_penable = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    i_psel = 1'b0; i_penable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    apb_xfer(16'h0048, 1'b0, 32'h0, 4'h0, 0, 2'b00, 32'h600DCAFE);

    // spurious response while idle
    i_response_ready = 1'b1; i_response_status = 2'b00; i_read_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spurious_pready", o_pready, 0);
      check("spurious_req_valid", o_request_valid, 0);
    end
    i_response_ready = 1'b0;
    // two back-to-back writes
    apb_xfer(16'h0100, 1'b1, 32'h01020304, 4'b1000, 0, 2'b00, 32'h0);
    apb_xfer(16'h0104, 1'b1, 32'h05060708, 4'b0101, 2, 2'b00, 32'h0);

    // PSEL dropped during BUSY: the access completes silently
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = 16'h0200; i_pwrite = 1'b0;
    @(negedge clk);
    i_psel = 1'b0;
    i_response_ready = 1'b1; i_response_status = 2'b10; i_read_data = 32'h77777777;
    @(negedge clk);
    i_response_ready = 1'b0;
    check("abort_pready", o_pready, 0);
    check("abort_pslverr", o_pslverr, 0);
    check("abort_prdata", o_prdata, 0);
    check("abort_req_valid", o_request_valid, 0);
    @(negedge clk);
    check("abort_idle_pready", o_pready, 0);
    apb_xfer(16'h0204, 1'b0, 32'h0, 4'h0, 1, 2'b00, 32'h89ABCDEF);

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    // no response: timeout error after TO BUSY cycles
    apb_xfer(16'h0300, 1'b0, 32'h0, 4'h0, 1000, 2'b00, 32'h12121212);
    // response in the expiry cycle: normal response wins
    apb_xfer(16'h0304, 1'b0, 32'h0, 4'h0, TO - 1, 2'b00, 32'h34343434);
`endif

    // randomized transfers
    for (int n = 0; n < 30; n++) begin
      logic [AW-1:0] a;
      logic          w;
      logic [DW-1:0] wd;
      logic [SW-1:0] sb;
      logic [DW-1:0] rd;
      a  = AW'($urandom);
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      sb = SW'($urandom);
      rd = $urandom;
      apb_xfer(a, w, wd, sb, int'($urandom_range(0, MAX_DELAY)),
               2'($urandom_range(0, 2)), rd);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_apb_bridge.md
Name: rggen_apb_bridge

Overview:
Host-side front end of the register block. It converts APB slave transfers into the single-outstanding internal request/response access that feeds every register instance, including the indirect registers. One request at a time, registered outputs. Register responses arrive pre-OR-reduced from the register array.

Parameters:
ADDRESS_WIDTH, 16, width of PADDR and of the internal access address
DATA_WIDTH, 32, bus data width; legal values 8, 16, 32, 64
TIMEOUT_CYCLES, 256, BUSY-state cycle limit; used only with the optional feature; must be ≥2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_psel  input  1  APB select
i_penable  input  1  APB enable
i_paddr  input  ADDRESS_WIDTH  APB address
i_pwrite  input  1  1 = write, 0 = read
i_pstrb  input  DATA_WIDTH/8  APB byte strobes
i_pwdata  input  DATA_WIDTH  APB write data
o_pready  output  1  APB ready
o_prdata  output  DATA_WIDTH  APB read data
o_pslverr  output  1  APB slave error
o_request_valid  output  1  internal access request
o_address  output  ADDRESS_WIDTH  internal access address
o_write  output  1  internal access direction
o_write_data  output  DATA_WIDTH  internal write data
o_strobe  output  DATA_WIDTH  internal bit-level strobe
i_response_ready  input  1  register array response valid
i_response_status  input  2  rggen_status: OKAY, EXOKAY, SLAVE_ERROR
i_read_data  input  DATA_WIDTH  register array read data

Behaviour:
- Clock and reset: single clock `clk`; asynchronous active-low reset `rst_n`.
- Reset: state IDLE; every output 0.
- FSM IDLE -> BUSY -> RESPOND -> IDLE.
- IDLE:
  - on i_psel=1 and i_penable=0 (setup phase), latch i_paddr and i_pwrite into o_address and o_write;
  - for writes, latch i_pwdata into o_write_data;
  - latch strobe: each i_pstrb bit is replicated 8 times; for reads, o_strobe is all-ones;
  - next cycle: BUSY with o_request_valid=1.
- BUSY:
  - request fields are held stable while o_request_valid=1;
  - on i_response_ready=1: o_request_valid drops next cycle and the FSM moves to RESPOND;
  - o_prdata takes i_read_data for reads and 0 for writes;
  - o_pslverr = (i_response_status == SLAVE_ERROR).
- RESPOND: o_pready=1 for exactly one cycle, then IDLE. o_pready, o_prdata and o_pslverr return to 0 in IDLE.
- Latency: minimum APB access is setup plus 2 access cycles, i.e. a response in the same cycle the request is valid.
- i_response_ready outside BUSY is ignored.
- i_psel deasserted during BUSY (protocol violation): the request still completes, and RESPOND is entered but its response is discarded. A new setup is accepted only in IDLE.
- Back-to-back: a setup phase in the cycle after RESPOND is accepted normally.
- Reset mid-operation: immediate return to IDLE, request dropped, all outputs 0.

Optional Feature:
Macro RGGEN_APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - a counter clears on BUSY entry and increments each BUSY cycle;
  - when it reaches TIMEOUT_CYCLES-1 without i_response_ready, the FSM goes to RESPOND with o_prdata=0 and o_pslverr=1, and o_request_valid is dropped;
  - i_response_ready in the same cycle as expiry takes priority (normal response).
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared package rggen_rtl_pkg holds:
  - enum rggen_status (OKAY=2'b00, EXOKAY=2'b01, SLAVE_ERROR=2'b10);
  - bridge state enum (IDLE, BUSY, RESPOND).
- One sub-module, rggen_bus_timeout_counter (clear, enable, expired), instantiated only under the macro.

Test Plan:
- Write: paddr=0x0010, pwdata=0xDEADBEEF, pstrb=4'b0011; array responds OKAY after 3 cycles -> o_strobe=0x0000FFFF, o_write=1, pready pulses once, pslverr=0, prdata=0.
- Read 0x0020 with immediate response OKAY, data 0x12345678 -> pready at 2nd access cycle, prdata=0x12345678, o_strobe=0xFFFFFFFF.
- Read with i_response_status=SLAVE_ERROR -> pslverr=1 with pready; request_valid low the next cycle.
- Reset asserted during BUSY -> all outputs 0 at once; after release, a fresh read completes normally.
- Spurious i_response_ready while IDLE, then two back-to-back writes -> no pready from the spurious pulse; both writes complete with correct addresses.
- With RGGEN_APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response -> pready with pslverr=1, prdata=0 after 8 BUSY cycles; response at cycle 8 -> OKAY wins.
